// File: rtl/traffic_timer_smart.sv
// Countdown timer for the smart traffic-light controller: prescales clk into ticks,
// counts down a requested length, pulses flicker near the end and holds done until restarted.
module traffic_timer_smart #(
    parameter logic [15:0] TICK_DIV       = 16'd10,
    parameter logic [4:0]  FLICKER_WINDOW = 5'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       t_start,
    input  logic [4:0] t_length,
    input  logic       t_freeze,
    output logic       t_done,
    output logic       t_flicker,
    output logic       t_running,
    output logic [4:0] t_remaining,
    output logic [1:0] dbg_state_o
);

    localparam int PW = (TICK_DIV <= 16'd2) ? 1 : $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 16'd1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          flicker_q, flicker_d;
    logic          tick;
    logic [4:0]    count_m1;

    assign count_m1 = count_q - 5'd1;
    assign tick     = (state_q == S_COUNT) && !t_freeze && !t_start && (presc_q == PRESC_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= 5'd0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            flicker_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            flicker_q <= flicker_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        presc_d   = presc_q;
        done_d    = done_q;
        flicker_d = 1'b0;
        if (t_start) begin
            // Restart wins over freeze and over any countdown in progress.
            count_d = t_length;
            presc_d = '0;
            done_d  = 1'b0;
            state_d = (t_length == 5'd0) ? S_EXPIRED : S_COUNT;
        end else begin
            case (state_q)
                S_COUNT: begin
                    if (tick) begin
                        presc_d = '0;
                        if (count_q <= 5'd1) begin
                            count_d = 5'd0;
                            done_d  = 1'b1;
                            state_d = S_EXPIRED;
                        end else begin
                            count_d   = count_m1;
                            flicker_d = (count_m1 <= FLICKER_WINDOW);
                        end
                    end else if (!t_freeze) begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                // A zero-length start lands here with done low; done follows one cycle later.
                S_EXPIRED: done_d = 1'b1;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    assign t_done      = done_q;
    assign t_flicker   = flicker_q;
    assign t_running   = (state_q == S_COUNT);
    assign t_remaining = count_q;
    assign dbg_state_o = state_q;

endmodule
